// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller: turns a load/store sitting in the EX/MEM
// register into one request to a multi-cycle data memory. It freezes the
// pipeline until the memory acknowledges or the wait limit expires.
//
// Handshake: mem_req_o stays high for every BUSY cycle, and address, data
// and write enable stay stable for as long as it is high. The memory
// completes the access with a single-cycle mem_ack_i pulse. For loads,
// mem_rdata_i is sampled only in that cycle. An ack seen while not BUSY
// is ignored.
module mem_stage_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WrData_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] RdData_o,
  output logic        stall_o,
  output logic        err_o,
  output logic [15:0] stall_cnt_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last wait-counter value before the access is abandoned.
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_raw;

  // Next-state and datapath decisions for the access FSM.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    wait_d    = wait_q;
    stall_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && (MemRead_i || MemWrite_i)) begin
          // A read+write combination is handled as a store.
          stall_raw = 1'b1;
          we_d      = MemWrite_i;
          addr_d    = Addr_i;
          wdata_d   = WrData_i;
          wait_d    = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        stall_raw = 1'b1;
        if (mem_ack_i) begin
          // The ack takes priority over a timeout in the same cycle.
          if (!we_q) rdata_d = mem_rdata_i;
          state_d = DONE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      DONE: begin
        // One unstalled cycle lets the pipeline advance past this access.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_d = (state_d == BUSY);
  end

  // Stall is masked by reset so the pipeline is released at once.
  assign stall_o = rst_n_i & stall_raw;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      wait_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign RdData_o    = rdata_q;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign dbg_state_o = state_q;

endmodule
